// File: rtl/aes_pkg.sv
// Shared AES types, round constants and GF(2^8) helpers for the key schedule and cipher rounds.
// Pure declarations and functions, no state.
// No handshake of its own.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        KEY_128     = 2'd0,
        KEY_192     = 2'd1,
        KEY_256     = 2'd2,
        KEY_256_ALT = 2'd3
    } key_len_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [3:0] nk_of(input key_len_e kl);
        case (kl)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KEY_128: return 4'd10;
            KEY_192: return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Index 0 and anything past 10 never reach the XOR path; return 0 rather than X.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Purpose: AES forward S-box for one byte (multiplicative inverse then affine map).
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 == x^-1 in GF(2^8); 254 = 2+4+...+128, so accumulate successive squares.
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Purpose: word-serial AES-128/192/256 key expansion streaming round keys 0..Nr.
// Latency: rk0 valid 4 cycles after start; one word per cycle; done 4*Nr+5 cycles after start at full rate.
// Backpressure: rk_valid && !rk_ready freezes word generation and holds every output stable.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  round_key,
    output logic [3:0]       rk_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [5:0]       i_q, i_d;
    logic [2:0]       j_q, j_d;
    logic [3:0]       rcon_q, rcon_d;
    logic [3:0]       nk_q, nk_d;
    logic [3:0]       nr_q, nr_d;
    logic [KEY_W-1:0] key_q, key_d;
    word_t            win_q [8];
    word_t            win_d [8];
    word_t            asm_q [3];
    word_t            asm_d [3];
    logic             rk_valid_q, rk_valid_d;
    logic [RK_W-1:0]  round_key_q, round_key_d;
    logic [3:0]       rk_idx_q, rk_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             stall;
    logic             hs;
    logic             adv;
    logic [5:0]       last_i;
    word_t            w_prev;
    word_t            tap;
    word_t            sub_in;
    word_t            sub_out;
    word_t            new_w;

    assign stall  = rk_valid_q && !rk_ready;
    assign hs     = rk_valid_q && rk_ready;
    assign adv    = (state_q == S_GEN) && !stall;
    assign last_i = {nr_q, 2'b11};
    assign w_prev = win_q[0];
    assign sub_in = (j_q == 3'd0) ? rot_word(w_prev) : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    // win_q[n] holds w[i-1-n]; w[i-Nk] therefore sits at tap Nk-1.
    always_comb begin
        case (nk_q)
            4'd4:    tap = win_q[3];
            4'd6:    tap = win_q[5];
            default: tap = win_q[7];
        endcase
    end

    always_comb begin
        if ({2'b00, nk_q} > i_q) begin
            new_w = key_q[KEY_W-1 -: 32];
        end else if (j_q == 3'd0) begin
            new_w = tap ^ sub_out ^ {rcon_of(rcon_q), 24'h000000};
        end else if (nk_q == 4'd8 && j_q == 3'd4) begin
            new_w = tap ^ sub_out;
        end else begin
            new_w = tap ^ w_prev;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        rcon_d      = rcon_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        key_d       = key_q;
        win_d       = win_q;
        asm_d       = asm_q;
        rk_valid_d  = rk_valid_q;
        round_key_d = round_key_q;
        rk_idx_d    = rk_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (hs) begin
            rk_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GEN;
                    key_d   = key;
                    nk_d    = nk_of(key_len_e'(key_len));
                    nr_d    = nr_of(key_len_e'(key_len));
                    i_d     = 6'd0;
                    j_d     = 3'd0;
                    rcon_d  = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            S_GEN: begin
                if (adv) begin
                    key_d    = key_q << 32;
                    win_d[0] = new_w;
                    for (int n = 1; n < 8; n++) begin
                        win_d[n] = win_q[n-1];
                    end
                    i_d = i_q + 6'd1;
                    if ({1'b0, j_q} == nk_q - 4'd1) begin
                        j_d    = 3'd0;
                        rcon_d = rcon_q + 4'd1;
                    end else begin
                        j_d = j_q + 3'd1;
                    end
                    case (i_q[1:0])
                        2'd0:    asm_d[0] = new_w;
                        2'd1:    asm_d[1] = new_w;
                        2'd2:    asm_d[2] = new_w;
                        default: begin
                            round_key_d = {asm_q[0], asm_q[1], asm_q[2], new_w};
                            rk_valid_d  = 1'b1;
                            rk_idx_d    = i_q[5:2];
                        end
                    endcase
                    if (i_q == last_i) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (hs) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= 6'd0;
            j_q         <= 3'd0;
            rcon_q      <= 4'd0;
            nk_q        <= 4'd0;
            nr_q        <= 4'd0;
            key_q       <= '0;
            for (int n = 0; n < 8; n++) begin
                win_q[n] <= '0;
            end
            for (int n = 0; n < 3; n++) begin
                asm_q[n] <= '0;
            end
            rk_valid_q  <= 1'b0;
            round_key_q <= '0;
            rk_idx_q    <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rcon_q      <= rcon_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            key_q       <= key_d;
            win_q       <= win_d;
            asm_q       <= asm_d;
            rk_valid_q  <= rk_valid_d;
            round_key_q <= round_key_d;
            rk_idx_q    <= rk_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rk_valid  = rk_valid_q;
    assign round_key = round_key_q;
    assign rk_idx    = rk_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Purpose: self-checking bench for aes_key_schedule against a word-list key expansion model.
// Latency: checks done timing at full rate and handshake ordering under random rk_ready.
// Backpressure: random rk_ready stalls with output-hold checks on every stalled cycle.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_W(256), .RK_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_idx    (rk_idx),
        .busy      (busy),
        .done      (done)
    );

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sbox_t [256];
    logic [7:0]   ex_t   [256];
    logic [7:0]   inv_t  [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];
    int           got_n;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from definition: inverse via powers of generator 3, then the affine map.
    task automatic build_sbox();
        logic [7:0] b;
        ex_t[0] = 8'h01;
        for (int n = 1; n < 256; n++) ex_t[n] = ex_t[n-1] ^ xt(ex_t[n-1]);
        inv_t[0] = 8'h00;
        for (int n = 0; n < 255; n++) inv_t[ex_t[n]] = ex_t[(255 - n) % 255];
        for (int a = 0; a < 256; a++) begin
            b = inv_t[a];
            sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model(input logic [255:0] k, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int n = 0; n < 8; n++) r[32*n +: 32] = $urandom;
        return r;
    endfunction

    // Caller sits #1 after a rising edge. abort_after >= 0 pulls rst after that many handshakes.
    task automatic run_job(input logic [255:0] k, input logic [1:0] kl, input bit rnd_rdy,
                           input bit poke, input int abort_after, input string name);
        int           nk, nr, cnt, nhs;
        bit           fin, seen;
        logic         pv, prdy;
        logic [127:0] prk;
        logic [3:0]   pidx;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        model(k, nk, nr);
        for (int r = 0; r < 15; r++) got_rk[r] = '0;
        got_n = 0;
        key = k; key_len = kl; start = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; key = rand256(); key_len = 2'($urandom_range(0, 3));
        cnt = 0; nhs = 0; fin = 0;
        chk({name, "_busy_start"}, busy, 1);
        pv = rk_valid; prdy = rk_ready; prk = round_key; pidx = rk_idx;
        while (cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (pv && prdy) begin
                chk({name, "_rk"}, prk, exp_rk[nhs]);
                chk({name, "_idx"}, pidx, nhs);
                got_rk[nhs] = prk;
                nhs++;
                got_n = nhs;
            end else if (pv) begin
                chk({name, "_stall_ctl"}, {rk_valid, rk_idx}, {1'b1, pidx});
                chk({name, "_stall_rk"}, round_key, prk);
            end
            if (done) begin
                chk({name, "_hs_count"}, nhs, nr + 1);
                chk({name, "_busy_done"}, busy, 0);
                if (!rnd_rdy) chk({name, "_latency"}, cnt, 4 * nr + 5);
                fin = 1;
                break;
            end
            chk({name, "_busy_run"}, busy, 1);
            if (abort_after >= 0 && nhs == abort_after) begin
                rst = 1'b0;
                @(posedge clk); #1;
                chk({name, "_rst_valid"}, rk_valid, 0);
                chk({name, "_rst_rk"}, round_key, 0);
                chk({name, "_rst_idx"}, rk_idx, 0);
                chk({name, "_rst_busy"}, busy, 0);
                chk({name, "_rst_done"}, done, 0);
                rst = 1'b1;
                seen = 0;
                repeat (8) begin
                    @(posedge clk); #1;
                    if (done || busy) seen = 1;
                end
                chk({name, "_rst_quiet"}, seen, 0);
                return;
            end
            if (poke && cnt >= 5 && cnt < 10) begin
                start = 1'b1; key = rand256(); key_len = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            rk_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = rk_valid; prdy = rk_ready; prk = round_key; pidx = rk_idx;
        end
        chk({name, "_finished"}, fin, 1);
        start = 1'b0; rk_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        build_sbox();
        rst = 1'b0; start = 1'b0; key = '0; key_len = 2'd0; rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rk_valid, 0);
        chk("reset_rk", round_key, 0);
        chk("reset_idx", rk_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_job(K128, 2'd0, 0, 0, -1, "a128");
        chk("a128_rk0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("a128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_job(K192, 2'd1, 0, 0, -1, "a192");
        chk("a192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        chk("a192_count", got_n, 13);

        run_job(K256, 2'd2, 0, 0, -1, "a256");
        chk("a256_rk1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("a256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_job(K256, 2'd2, 1, 0, -1, "a256_bp");
        chk("a256_bp_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("a256_bp_count", got_n, 15);

        run_job(K256, 2'd3, 0, 1, -1, "kl3_poke");
        chk("kl3_rk1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("kl3_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_job(rand256(), 2'd2, 1, 0, 4, "abort");
        run_job(K128, 2'd0, 0, 0, -1, "post_rst");
        chk("post_rst_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 6; n++) begin
            run_job(rand256(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
